// File: rtl/serial_pattern_tx_if.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx_if
//
// Bundles the load handshake and the serial output side of serial_pattern_tx.
//
// Signals:
//   load_valid  source -> tx   load_data / repeat_n are valid
//   load_data   source -> tx   word to send, MSB first
//   repeat_n    source -> tx   number of transmissions (0 behaves as 1)
//   load_ready  tx -> source   transmitter idle and able to accept a word
//   out_bit     tx -> sink     serial data, 0 whenever out_valid is 0
//   out_valid   tx -> sink     out_bit carries a payload bit this cycle
//   busy        tx -> sink     transmission (including gaps) in progress
//   done        tx -> sink     pulse on the last bit of the last repetition
//   match_cnt   tx -> sink     non-overlapping 10101 count (0 when disabled)
//
// Modports:
//   master  the word source / observer side
//   slave   the transmitter
// ---------------------------------------------------------------------------
interface serial_pattern_tx_if #(
    parameter int WIDTH = 16
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic [3:0]       repeat_n;
    logic             load_ready;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [15:0]      match_cnt;

    modport master (
        output load_valid,
        output load_data,
        output repeat_n,
        input  load_ready,
        input  out_bit,
        input  out_valid,
        input  busy,
        input  done,
        input  match_cnt
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  repeat_n,
        output load_ready,
        output out_bit,
        output out_valid,
        output busy,
        output done,
        output match_cnt
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
//
// Serial bit-stream transmitter. A word accepted over a valid/ready handshake
// is shifted out MSB first, one bit per clock, and optionally repeated with
// GAP idle cycles between repetitions. It feeds the serial sequence detectors
// downstream.
//
// Parameters:
//   WIDTH  word length in bits (must be >= 2)
//   GAP    idle cycles between repetitions of the same word (0 = back-to-back)
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   tx   serial_pattern_tx_if.slave: load_valid/load_data/repeat_n in,
//        load_ready/out_bit/out_valid/busy/done/match_cnt out
//
// Build option:
//   PTX_MATCH_CNT_EN  when defined, a non-overlapping 10101 detector watches
//                     the transmitted payload bits and match_cnt counts its
//                     hits (saturating). When undefined match_cnt is 0.
//
// All outputs are decoded from registered state; there is no combinational
// path from the interface inputs to any output.
// ---------------------------------------------------------------------------
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int GAP   = 0
) (
    input  logic               clk,
    input  logic               rst,
    serial_pattern_tx_if.slave tx
);

    localparam int BCW = $clog2(WIDTH);
    // A zero-cycle gap still needs a 1-bit counter to keep the declaration legal.
    localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [GCW-1:0]   gapcnt_q, gapcnt_d;
    logic [3:0]       rep_left_q, rep_left_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;

    logic             shifting;
    logic             last_bit;

    assign shifting = (state_q == ST_SHIFT);
    assign last_bit = shifting && (bitcnt_q == BIT_LAST);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        gapcnt_d   = gapcnt_q;
        rep_left_d = rep_left_q;
        shreg_d    = shreg_q;
        word_d     = word_q;

        unique case (state_q)
            ST_IDLE: begin
                // load_ready is high throughout IDLE, so valid alone completes
                // the handshake here.
                if (tx.load_valid) begin
                    shreg_d    = tx.load_data;
                    word_d     = tx.load_data;
                    rep_left_d = (tx.repeat_n == 4'd0) ? 4'd1 : tx.repeat_n;
                    bitcnt_d   = '0;
                    state_d    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                bitcnt_d = bitcnt_q + BCW'(1);
                if (bitcnt_q == BIT_LAST) begin
                    rep_left_d = rep_left_q - 4'd1;
                    if (rep_left_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end else if (GAP == 0) begin
                        // Back-to-back repetition: next word's MSB follows
                        // the current LSB with no idle cycle.
                        shreg_d  = word_q;
                        bitcnt_d = '0;
                    end else begin
                        state_d  = ST_GAP;
                        gapcnt_d = '0;
                    end
                end
            end

            ST_GAP: begin
                gapcnt_d = gapcnt_q + GCW'(1);
                if (gapcnt_q == GAP_LAST) begin
                    shreg_d  = word_q;
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers (reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            gapcnt_q   <= '0;
            rep_left_q <= '0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            gapcnt_q   <= gapcnt_d;
            rep_left_q <= rep_left_d;
        end
    end

    // -----------------------------------------------------------------------
    // Data registers (no reset: contents only matter once a word is loaded)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        word_q  <= word_d;
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    assign tx.load_ready = (state_q == ST_IDLE);
    assign tx.busy       = (state_q != ST_IDLE);
    assign tx.out_valid  = shifting;
    assign tx.out_bit    = shifting & shreg_q[WIDTH-1];
    assign tx.done       = last_bit && (rep_left_q == 4'd1);

`ifdef PTX_MATCH_CNT_EN
    // Detector state = longest suffix of the received bits that is a prefix
    // of 10101. A full match restarts from empty, which makes the counted
    // occurrences non-overlapping.
    typedef enum logic [2:0] {
        M_S0 = 3'd0,
        M_S1 = 3'd1,
        M_S2 = 3'd2,
        M_S3 = 3'd3,
        M_S4 = 3'd4
    } mstate_t;

    mstate_t     mst_q, mst_d;
    logic [15:0] match_cnt_q, match_cnt_d;
    logic        hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        mst_d       = mst_q;
        hit         = 1'b0;
        if (shifting) begin
            unique case (mst_q)
                M_S0: mst_d = shreg_q[WIDTH-1] ? M_S1 : M_S0;
                M_S1: mst_d = shreg_q[WIDTH-1] ? M_S1 : M_S2;
                M_S2: mst_d = shreg_q[WIDTH-1] ? M_S3 : M_S0;
                M_S3: mst_d = shreg_q[WIDTH-1] ? M_S1 : M_S4;
                M_S4: begin
                    mst_d = M_S0;
                    hit   = shreg_q[WIDTH-1];
                end
                default: mst_d = M_S0;
            endcase
        end
        match_cnt_d = hit ? sat_inc(match_cnt_q) : match_cnt_q;
    end

    // Detector state survives gaps, repetitions and new words; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_q       <= M_S0;
            match_cnt_q <= '0;
        end else begin
            mst_q       <= mst_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign tx.match_cnt = match_cnt_q;
`else
    assign tx.match_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;
    localparam int W = 16;
`ifdef PTX_MATCH_CNT_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          load_valid = 1'b0;
    logic [W-1:0]  load_data  = '0;
    logic [3:0]    repeat_n   = '0;
    bit            chk_en     = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_pattern_tx_if #(.WIDTH(W)) ifc0 ();
    serial_pattern_tx_if #(.WIDTH(W)) ifc2 ();

    assign ifc0.load_valid = load_valid;
    assign ifc0.load_data  = load_data;
    assign ifc0.repeat_n   = repeat_n;
    assign ifc2.load_valid = load_valid;
    assign ifc2.load_data  = load_data;
    assign ifc2.repeat_n   = repeat_n;

    serial_pattern_tx #(.WIDTH(W), .GAP(0)) dut0 (.clk(clk), .rst(rst), .tx(ifc0));
    serial_pattern_tx #(.WIDTH(W), .GAP(2)) dut2 (.clk(clk), .rst(rst), .tx(ifc2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each accepted word becomes a queue of per-cycle
    // events {valid, bit, done}; an empty queue means the transmitter idles.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic v;
        logic b;
        logic d;
    } ev_t;

    ev_t q0[$];
    ev_t q2[$];
    ev_t tmpq[$];
    ev_t me;
    ev_t f0, f2;

    int         since[2] = '{0, 0};
    logic [4:0] hist[2]  = '{5'd0, 5'd0};
    int         mcnt[2]  = '{0, 0};

    function automatic void build(input logic [W-1:0] d, input logic [3:0] rn, input int gap);
        int  r_eff;
        ev_t e;
        tmpq.delete();
        r_eff = (rn == 4'd0) ? 1 : int'(rn);
        for (int r = 0; r < r_eff; r++) begin
            for (int i = 0; i < W; i++) begin
                e.v = 1'b1;
                e.b = d[W-1-i];
                e.d = (r == r_eff - 1) && (i == W - 1);
                tmpq.push_back(e);
            end
            if (r < r_eff - 1)
                for (int g = 0; g < gap; g++) begin
                    e = '0;
                    tmpq.push_back(e);
                end
        end
    endfunction

    // Non-overlapping search: a hit needs five bits since the last hit.
    function automatic void scan(input int k, input logic b);
        hist[k] = {hist[k][3:0], b};
        since[k]++;
        if (since[k] >= 5 && hist[k] == 5'b10101) begin
            if (mcnt[k] < 65535) mcnt[k]++;
            since[k] = 0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q2.delete();
            for (int k = 0; k < 2; k++) begin
                since[k] = 0;
                hist[k]  = '0;
                mcnt[k]  = 0;
            end
        end else begin
            if (q0.size() > 0) begin
                me = q0.pop_front();
                if (me.v) scan(0, me.b);
            end else if (load_valid) begin
                build(load_data, repeat_n, 0);
                q0 = tmpq;
            end
            if (q2.size() > 0) begin
                me = q2.pop_front();
                if (me.v) scan(1, me.b);
            end else if (load_valid) begin
                build(load_data, repeat_n, 2);
                q2 = tmpq;
            end
        end
    end

    task automatic check_inst(input string tag, input bit has, input ev_t e, input int mc,
                              input logic lr, input logic bz, input logic ov,
                              input logic ob, input logic dn, input logic [15:0] m);
        logic [15:0] em;
        em = MC_EN ? mc[15:0] : 16'd0;
        chk({tag, ".load_ready"}, lr, !has);
        chk({tag, ".busy"},       bz, has);
        chk({tag, ".out_valid"},  ov, has ? e.v : 1'b0);
        chk({tag, ".out_bit"},    ob, has ? e.b : 1'b0);
        chk({tag, ".done"},       dn, has ? e.d : 1'b0);
        chk({tag, ".match_cnt"},  m,  em);
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            f0 = '0;
            f2 = '0;
            if (q0.size() > 0) f0 = q0[0];
            if (q2.size() > 0) f2 = q2[0];
            check_inst("g0", q0.size() > 0, f0, mcnt[0], ifc0.load_ready, ifc0.busy,
                       ifc0.out_valid, ifc0.out_bit, ifc0.done, ifc0.match_cnt);
            check_inst("g2", q2.size() > 0, f2, mcnt[1], ifc2.load_ready, ifc2.busy,
                       ifc2.out_valid, ifc2.out_bit, ifc2.done, ifc2.match_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((ifc0.busy || ifc2.busy) && n < limit) begin
            tick();
            n++;
        end
        chk("wait_idle", {31'd0, ifc0.busy | ifc2.busy}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed table
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   rep;
        int           len0;
        int           len2;
        int           gap2;
        int           mdelta;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, b0, b2, d0, d2, g2;
        logic [15:0] m0b, m2b, diff;

        // Match deltas depend on detector state carried over from the
        // previous word: AAAA leaves "1010" pending, so 8001 completes a match.
        tbl[0] = '{16'hA800, 4'd1, 16, 16, 0, 1};
        tbl[1] = '{16'hAAAA, 4'd1, 16, 16, 0, 2};
        tbl[2] = '{16'h8001, 4'd0, 16, 16, 0, 1};
        tbl[3] = '{16'h8001, 4'd1, 16, 16, 0, 0};
        tbl[4] = '{16'hF00F, 4'd3, 48, 52, 4, 0};
        tbl[5] = '{16'h0015, 4'd2, 32, 34, 2, 2};

        #2;
        chk("rst.load_ready0", ifc0.load_ready, 1);
        chk("rst.busy0",       ifc0.busy,       0);
        chk("rst.out_valid0",  ifc0.out_valid,  0);
        chk("rst.out_bit0",    ifc0.out_bit,    0);
        chk("rst.done0",       ifc0.done,       0);
        chk("rst.match0",      ifc0.match_cnt,  0);
        chk("rst.load_ready2", ifc2.load_ready, 1);
        chk("rst.busy2",       ifc2.busy,       0);

        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        for (int t = 0; t < 6; t++) begin
            wait_idle(200);
            m0b        = ifc0.match_cnt;
            m2b        = ifc2.match_cnt;
            load_valid = 1'b1;
            load_data  = tbl[t].data;
            repeat_n   = tbl[t].rep;
            tick();
            load_valid = 1'b0;
            chk("tbl.first_bit0", ifc0.out_bit, tbl[t].data[W-1]);
            chk("tbl.first_bit2", ifc2.out_bit, tbl[t].data[W-1]);
            b0 = 0; b2 = 0; d0 = 0; d2 = 0; g2 = 0; n = 0;
            while ((ifc0.busy || ifc2.busy) && n < 300) begin
                b0 += int'(ifc0.busy);
                b2 += int'(ifc2.busy);
                d0 += int'(ifc0.done);
                d2 += int'(ifc2.done);
                if (ifc2.busy && !ifc2.out_valid) g2++;
                tick();
                n++;
            end
            chk("tbl.busy_len0", b0, tbl[t].len0);
            chk("tbl.busy_len2", b2, tbl[t].len2);
            chk("tbl.gap2",      g2, tbl[t].gap2);
            chk("tbl.done0",     d0, 1);
            chk("tbl.done2",     d2, 1);
            chk("tbl.ready_after0", ifc0.load_ready, 1);
            chk("tbl.ready_after2", ifc2.load_ready, 1);
            diff = ifc0.match_cnt - m0b;
            chk("tbl.match_delta0", diff, MC_EN ? tbl[t].mdelta : 0);
            diff = ifc2.match_cnt - m2b;
            chk("tbl.match_delta2", diff, MC_EN ? tbl[t].mdelta : 0);
        end

        // load_valid held with a new word during a transmission
        wait_idle(200);
        load_valid = 1'b1;
        load_data  = 16'hC3A5;
        repeat_n   = 4'd2;
        tick();
        load_data  = 16'hDA3C;
        repeat_n   = 4'd1;
        n = 0;
        while (ifc0.busy && n < 100) begin
            chk("hold.ready_low0", ifc0.load_ready, 0);
            tick();
            n++;
        end
        chk("hold.busy_len0",   n, 32);
        chk("hold.idle_ready0", ifc0.load_ready, 1);
        tick();
        chk("hold.accept_busy0", ifc0.busy, 1);
        chk("hold.accept_bit0",  ifc0.out_bit, 1);
        n = 0;
        while (ifc2.busy && n < 100) begin
            tick();
            n++;
        end
        chk("hold.idle_ready2", ifc2.load_ready, 1);
        tick();
        load_valid = 1'b0;
        chk("hold.accept_busy2", ifc2.busy, 1);
        chk("hold.accept_bit2",  ifc2.out_bit, 1);
        wait_idle(200);

        // Asynchronous reset during bit 7
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        repeat_n   = 4'd2;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("arst.pre_bit", ifc0.out_bit, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid0", ifc0.out_valid, 0);
        chk("arst.out_bit0",   ifc0.out_bit,   0);
        chk("arst.busy0",      ifc0.busy,      0);
        chk("arst.done0",      ifc0.done,      0);
        chk("arst.match0",     ifc0.match_cnt, 0);
        chk("arst.ready0",     ifc0.load_ready, 1);
        chk("arst.busy2",      ifc2.busy,      0);
        chk("arst.match2",     ifc2.match_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        load_valid = 1'b1;
        load_data  = 16'hA800;
        repeat_n   = 4'd1;
        tick();
        load_valid = 1'b0;
        chk("arst.fresh_b0", ifc0.out_bit, 1);
        tick();
        chk("arst.fresh_b1", ifc0.out_bit, 0);
        tick();
        chk("arst.fresh_b2", ifc0.out_bit, 1);
        wait_idle(200);
        chk("arst.fresh_match0", ifc0.match_cnt, MC_EN ? 1 : 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            load_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       load_data = 16'hAAAA;
                1:       load_data = 16'h5555 ^ W'($urandom_range(0, 15));
                default: load_data = W'($urandom);
            endcase
            repeat_n = 4'($urandom_range(0, 3));
            tick();
        end
        load_valid = 1'b0;
        wait_idle(300);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
